// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter that shares an 8:1 bit-mux among eight requesters.
// One requester owns the mux at a time. A one-cycle break-before-make gap
// separates owners, so the select never changes while an owner is active.
//
// Parameters:
//   MAX_HOLD  maximum tenure in cycles (1..255). It is used only when
//             MUX_RR_ARBITER_HOLD_TIMEOUT_EN is defined.
//
// Optional feature macro:
//   MUX_RR_ARBITER_HOLD_TIMEOUT_EN  bounds each tenure to MAX_HOLD cycles.
//
// Ports:
//   clk    in   1  clock; all state updates on the rising edge
//   rst_n  in   1  synchronous active-low reset
//   req    in   8  level request per requester
//   a      in   8  data bit per requester
//   gnt    out  8  registered one-hot grant; zero when there is no owner
//   s      out  3  registered mux select; current or last owner
//   busy   out  1  registered; high exactly when gnt is nonzero
//   y      out  1  a[s] while busy, else 0 (combinational)
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] a,
    output logic [7:0] gnt,
    output logic [2:0] s,
    output logic       busy,
    output logic       y
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_rr_arbiter: MAX_HOLD must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] s_q, s_d;
    logic       busy_q, busy_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] win;
`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    // First requester found scanning ptr, ptr+1, ... ptr+7 (mod 8).
    // The scan runs from the far end, so the last hit is the closest to ptr.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        rr_pick = p;
        for (int unsigned i = 8; i > 0; i--) begin
            idx = 3'(p + 3'(i - 1));
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign win = rr_pick(req, ptr_q);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, GAP: begin
                state_d = (|req) ? GRANT : IDLE;
            end
            GRANT: begin
                if (!req[s_q]) begin
                    state_d = GAP;
                end
`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
                else if (cnt_q == 8'(MAX_HOLD)) begin
                    state_d = GAP;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic: next values of the registered outputs
    always_comb begin
        gnt_d  = gnt_q;
        s_d    = s_q;
        busy_d = busy_q;
        ptr_d  = ptr_q;
`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
        cnt_d  = cnt_q;
`endif
        if (state_d == GRANT && state_q != GRANT) begin
            // A new owner takes the mux, and the pointer moves past it.
            gnt_d  = 8'(1) << win;
            s_d    = win;
            busy_d = 1'b1;
            ptr_d  = 3'(win + 3'd1);
`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
            cnt_d  = 8'd1;
`endif
        end else if (state_d == GRANT) begin
`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
            cnt_d  = 8'(cnt_q + 8'd1);
`endif
        end else begin
            // GAP or IDLE: release the grant and keep the last select.
            gnt_d  = '0;
            busy_d = 1'b0;
`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
            cnt_d  = '0;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign s    = s_q;
    assign busy = busy_q;
    assign y    = busy_q ? a[s_q] : 1'b0;

endmodule
